// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-entry valid/ready holding register
// Bit timing is derived from CLK_FREQ_HZ / BAUD_RATE; samples land at nominal bit centers.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            deliver;
  logic            rxs;

  assign rxs = sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Only a real 1->0 transition starts a frame; a stuck-low line does not.
        if (prev_q && !rxs) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rxs) begin
            state_d = DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = rxs;
          cnt_d          = FULL_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rxs) begin
            deliver = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot freed by a same-cycle transfer may be refilled without a bubble.
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx at 4 clocks per bit
module tb_uart_rx;
  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 3000000;
  localparam int CPB    = CLK_HZ / BAUD;
  // Two synchronizer flops plus the edge-detect cycle precede the start sample;
  // the byte appears one cycle after the stop sample.
  localparam int LAT    = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int         xfer_cyc[$];
  logic [7:0] xfer_dat[$];
  int         fe_cyc[$];
  int         ov_cyc[$];
  bit         busy_seen;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (rx_valid && rx_ready) begin
        xfer_cyc.push_back(cyc);
        xfer_dat.push_back(rx_data);
      end
      if (frame_err) fe_cyc.push_back(cyc);
      if (overrun)   ov_cyc.push_back(cyc);
      if (busy)      busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    xfer_cyc.delete();
    xfer_dat.delete();
    fe_cyc.delete();
    ov_cyc.delete();
    busy_seen = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int f);
    f   = cyc;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop;
    wait_cyc(CPB);
  endtask

  int         f1, f2;
  int         exp_cyc[$];
  logic [7:0] exp_dat[$];
  int         exp_fe[$];
  logic [7:0] b;
  bit         good;

  initial begin
    rxd      = 1'b1;
    rx_ready = 1'b1;
    resetn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
    resetn = 1'b1;
    wait_cyc(4);

    // single byte, consumer always ready
    clear_mon();
    send_frame(8'hA5, 1'b1, f1);
    wait_cyc(CPB + 4);
    chk("a5_count", xfer_dat.size(), 1);
    if (xfer_dat.size() >= 1) begin
      chk("a5_data", xfer_dat[0], 8'hA5);
      chk("a5_latency", xfer_cyc[0], f1 + LAT);
    end
    chk("a5_errs", fe_cyc.size() + ov_cyc.size(), 0);
    chk("a5_valid_1cyc", rx_valid, 1'b0);

    // overrun while holding register is full
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, f1);
    send_frame(8'hC3, 1'b1, f2);
    wait_cyc(CPB + 4);
    chk("ovr_valid_held", rx_valid, 1'b1);
    chk("ovr_data_held", rx_data, 8'h3C);
    chk("ovr_count", ov_cyc.size(), 1);
    if (ov_cyc.size() >= 1) chk("ovr_time", ov_cyc[0], f2 + LAT);
    rx_ready = 1'b1;
    wait_cyc(3);
    chk("ovr_xfer_count", xfer_dat.size(), 1);
    if (xfer_dat.size() >= 1) chk("ovr_xfer_data", xfer_dat[0], 8'h3C);
    chk("ovr_valid_clr", rx_valid, 1'b0);

    // bad stop bit, line then stays low
    clear_mon();
    send_frame(8'h55, 1'b0, f1);
    wait_cyc(3 * CPB);
    chk("fe_count", fe_cyc.size(), 1);
    if (fe_cyc.size() >= 1) chk("fe_time", fe_cyc[0], f1 + LAT);
    chk("fe_no_xfer", xfer_dat.size(), 0);
    chk("fe_low_idle", busy, 1'b0);
    rxd = 1'b1;
    wait_cyc(CPB);
    send_frame(8'h5A, 1'b1, f1);
    wait_cyc(CPB + 4);
    chk("fe_recover_count", xfer_dat.size(), 1);
    if (xfer_dat.size() >= 1) chk("fe_recover_data", xfer_dat[0], 8'h5A);

    // short glitch rejected in START
    clear_mon();
    rxd = 1'b0;
    wait_cyc(CPB / 4);
    rxd = 1'b1;
    wait_cyc(2 * CPB);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_now", busy, 1'b0);
    chk("glitch_pulses", xfer_dat.size() + fe_cyc.size() + ov_cyc.size(), 0);

    // reset during bit 4 of 0xFF
    clear_mon();
    rxd = 1'b0;
    wait_cyc(CPB);
    rxd = 1'b1;
    wait_cyc(4 * CPB + CPB / 2);
    #2 resetn = 1'b0;
    #1 chk("midrst_outs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    wait_cyc(2 * CPB);
    chk("midrst_idle", busy, 1'b0);
    send_frame(8'h12, 1'b1, f1);
    wait_cyc(CPB + 4);
    chk("midrst_count", xfer_dat.size(), 1);
    if (xfer_dat.size() >= 1) chk("midrst_data", xfer_dat[0], 8'h12);

    // back-to-back frames
    clear_mon();
    send_frame(8'h01, 1'b1, f1);
    send_frame(8'h80, 1'b1, f2);
    wait_cyc(CPB + 4);
    chk("b2b_count", xfer_dat.size(), 2);
    if (xfer_dat.size() >= 2) begin
      chk("b2b_data0", xfer_dat[0], 8'h01);
      chk("b2b_data1", xfer_dat[1], 8'h80);
      chk("b2b_time1", xfer_cyc[1], f2 + LAT);
    end
    chk("b2b_errs", fe_cyc.size() + ov_cyc.size(), 0);

    // randomized frames against the reference model
    clear_mon();
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, f1);
      if (good) begin
        exp_dat.push_back(b);
        exp_cyc.push_back(f1 + LAT);
      end else begin
        exp_fe.push_back(f1 + LAT);
      end
      rxd = 1'b1;
      wait_cyc(CPB * (good ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1))));
    end
    wait_cyc(CPB + 4);
    chk("rnd_count", xfer_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (i < xfer_dat.size()) begin
        chk($sformatf("rnd_data%0d", i), xfer_dat[i], exp_dat[i]);
        chk($sformatf("rnd_time%0d", i), xfer_cyc[i], exp_cyc[i]);
      end
    end
    chk("rnd_fe_count", fe_cyc.size(), exp_fe.size());
    for (int i = 0; i < exp_fe.size(); i++) begin
      if (i < fe_cyc.size()) chk($sformatf("rnd_fe_time%0d", i), fe_cyc[i], exp_fe[i]);
    end
    chk("rnd_ovr", ov_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 12000000, which is the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, which is the serial bit rate.
REQ-003 The module SHALL define CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer truncation; 104 at defaults), and SHALL require CLKS_PER_BIT >= 4.
REQ-004 The module SHALL have port clk: input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-005 The module SHALL have port resetn: input, 1 bit, reset; reset is asynchronous and active-low.
REQ-006 The module SHALL have port rxd: input, 1 bit, the asynchronous UART line (idle high; 8N1, LSB first).
REQ-007 The module SHALL have port rx_data: output, 8 bits, the received byte; it is valid only while rx_valid is high.
REQ-008 The module SHALL have port rx_valid: output, 1 bit, high while the holding register contains an unconsumed byte.
REQ-009 The module SHALL have port rx_ready: input, 1 bit, consumer acceptance; a transfer occurs on any cycle with rx_valid && rx_ready.
REQ-010 The module SHALL have port frame_err: output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-011 The module SHALL have port overrun: output, 1 bit, a one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-012 The module SHALL have port busy: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-013 rxd SHALL pass through a two-flop synchronizer (both flops reset to 1); all FSM decisions SHALL use the synchronized value rxs.
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-015 In IDLE, a falling edge of rxs (previous 1, current 0) SHALL move the FSM to START and load the bit counter with CLKS_PER_BIT/2 - 1; a line that is held low without a falling edge SHALL NOT start a frame.
REQ-016 In START, when the counter reaches 0: if rxs = 0, the FSM SHALL go to DATA with the counter at CLKS_PER_BIT-1 and bit index 0; otherwise it SHALL return to IDLE with no output activity (glitch rejection).
REQ-017 In DATA, each time the counter reaches 0, rxs SHALL be shifted in as bit [index]; the counter SHALL reload to CLKS_PER_BIT-1 and the index SHALL increment; after index 7 the FSM SHALL go to STOP.
REQ-018 In STOP, when the counter reaches 0: rxs = 1 SHALL deliver the byte (REQ-019); rxs = 0 SHALL pulse frame_err for one cycle and discard the byte; in both cases the FSM SHALL go to IDLE.
REQ-019 On delivery, if rx_valid = 0, or rx_valid && rx_ready in the same cycle, then rx_data SHALL load the new byte and rx_valid SHALL be 1 on the next cycle (back-to-back with no gap); otherwise the byte SHALL be dropped, rx_data SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-020 rx_valid SHALL clear the cycle after a transfer unless a delivery occurs in that same cycle.
REQ-021 While rx_valid && !rx_ready, rx_data SHALL hold stable.
REQ-022 Sampling SHALL occur at the nominal bit centers: the start bit at detect+CLKS_PER_BIT/2, and data bit n at detect+CLKS_PER_BIT/2+(n+1)*CLKS_PER_BIT cycles, where detect is the cycle in which the falling edge of rxs is seen.
REQ-023 Latency SHALL be 1 cycle from the stop-sample cycle to rx_valid high.
REQ-024 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap; the bit index SHALL be 3 bits.

Reset
REQ-025 While resetn = 0, the module SHALL hold: FSM = IDLE, synchronizer flops = 1, previous rxs = 1, counter = 0, index = 0, shift register = 0, rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; no partial byte SHALL ever be delivered.
REQ-027 After reset release, a new frame SHALL be recognized only on a fresh falling edge of rxs.

Verification
REQ-028 With CLKS_PER_BIT = 4 (CLK_FREQ_HZ=12000000, BAUD_RATE=3000000), send 0xA5 with rx_ready=1 -> rx_valid high for 1 cycle with rx_data=0xA5, exactly 1 cycle after the stop-sample cycle; frame_err=0 and overrun=0.
REQ-029 With rx_ready=0, send 0x3C then 0xC3 -> rx_data stays 0x3C with rx_valid held high; overrun pulses once at the 0xC3 stop sample; raising rx_ready then yields one transfer of 0x3C.
REQ-030 Send 0x55 with the stop bit driven 0 -> frame_err pulses once, rx_valid stays 0, and the FSM waits for rxd high plus a new falling edge before starting another frame.
REQ-031 Drive rxd low for 1 bit-time/4 then high -> START rejects it and returns to IDLE; busy drops; no output pulses.
REQ-032 Assert resetn low during bit 4 of 0xFF, release, then send 0x12 -> only 0x12 is delivered; all outputs are 0 during reset.
REQ-033 Send 0x01 and 0x80 back-to-back with rx_ready=1 -> both bytes are delivered in order with no loss and no error pulses.
